// File: rtl/sc_io_display_if.sv
// sc_io_display_if
//   Bundles the data path between the computer's memory-mapped I/O output
//   and the seven-segment display stage.
//
//   Handshake: there is no valid/ready pair. `result` is a level-held value;
//   the display stage samples it whenever it is idle and starts a conversion
//   when it differs from the last accepted value. `busy` reports that a
//   conversion is in flight. The outputs (`hex*`, `bcd`, `ovf`) are
//   registered and change only on the cycle a conversion completes.
//
//   Signals:
//     result    [31:0]  value from the data-memory I/O output (low 20 bits used)
//     hex0..5   [6:0]   active-low segments, bit0 = a .. bit6 = g, hex0 = units
//     bcd       [23:0]  BCD of the displayed value, bcd[3:0] = units
//     busy              conversion in progress
//     ovf               displayed value was saturated to 999999
//     state_dbg [1:0]   FSM state for observation (0 IDLE, 1 CONV, 2 UPDATE)
//
//   Modports: master = producer / observer, slave = display stage.
interface sc_io_display_if;
   logic [31:0] result;
   logic [6:0]  hex0;
   logic [6:0]  hex1;
   logic [6:0]  hex2;
   logic [6:0]  hex3;
   logic [6:0]  hex4;
   logic [6:0]  hex5;
   logic [23:0] bcd;
   logic        busy;
   logic        ovf;
   logic [1:0]  state_dbg;

   modport master (
      output result,
      input  hex0, hex1, hex2, hex3, hex4, hex5, bcd, busy, ovf, state_dbg
   );

   modport slave (
      input  result,
      output hex0, hex1, hex2, hex3, hex4, hex5, bcd, busy, ovf, state_dbg
   );
endinterface

// File: rtl/sc_io_display.sv
// sc_io_display
//   Output stage of the single-cycle computer. Shows result[19:0] as a
//   six-digit decimal number on the seven-segment displays. Binary to BCD
//   uses a sequential shift-and-add-3 engine (one bit per clock) that is
//   re-triggered whenever the displayed value changes. Values above 999999
//   are saturated to 999999 and flagged on `ovf`.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    sc_io_display_if.slave (result in; hex0..5, bcd, busy, ovf,
//            state_dbg out)
//
//   Build option: define SC_IO_DISPLAY_BLANK_EN for leading-zero blanking
//   (digits above the most significant non-zero digit show all segments
//   off; hex0 is never blanked). Without it all six digits are driven.
module sc_io_display #(
   parameter int WIDTH = 20
) (
   input logic             clk,
   input logic             reset,
   sc_io_display_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(999999);
   localparam logic [6:0]       SEG_ZERO  = 7'h40;
   localparam logic [6:0]       SEG_BLANK = 7'h7F;
`ifdef SC_IO_DISPLAY_BLANK_EN
   localparam logic [6:0]       HEX_UPPER_RST = SEG_BLANK;
`else
   localparam logic [6:0]       HEX_UPPER_RST = SEG_ZERO;
`endif

   state_t           state;
   logic [WIDTH-1:0] last;
   logic [WIDTH-1:0] shreg;
   logic [23:0]      acc;
   logic [4:0]       cnt;
   logic             ovf_pend;
   logic [23:0]      bcd_q;
   logic [6:0]       hex_q [6];
   logic             busy_q;
   logic             ovf_q;

   logic [WIDTH-1:0] new_val;
   logic [23:0]      acc_adj;
   logic [6:0]       hex_next [6];

   assign new_val = bus.result[WIDTH-1:0];

   // The upper result bits are deliberately ignored by this stage.
   logic unused_result_hi;
   assign unused_result_hi = ^bus.result[31:WIDTH];

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   // Add-3 correction applied to every BCD nibble before the shift.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < 6; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // Segment patterns for the finished conversion, evaluated from the top
   // digit down so blanking can track whether a non-zero digit was seen.
`ifdef SC_IO_DISPLAY_BLANK_EN
   logic blank_seen;
`endif
   always_comb begin
`ifdef SC_IO_DISPLAY_BLANK_EN
      blank_seen = 1'b0;
`endif
      for (int i = 5; i >= 0; i--) begin
         hex_next[i] = seg7(acc[4*i +: 4]);
`ifdef SC_IO_DISPLAY_BLANK_EN
         if (acc[4*i +: 4] != 4'd0) begin
            blank_seen = 1'b1;
         end
         if (!blank_seen && i != 0) begin
            hex_next[i] = SEG_BLANK;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last     <= '0;
         shreg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         bcd_q    <= '0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         hex_q[0] <= SEG_ZERO;
         for (int i = 1; i < 6; i++) begin
            hex_q[i] <= HEX_UPPER_RST;
         end
      end else begin
         case (state)
            IDLE: begin
               if (new_val != last) begin
                  last     <= new_val;
                  shreg    <= (new_val > MAX_VAL) ? MAX_VAL : new_val;
                  ovf_pend <= (new_val > MAX_VAL);
                  acc      <= '0;
                  cnt      <= '0;
                  busy_q   <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               // {acc, shreg} shifts left one with the corrected acc.
               acc   <= {acc_adj[22:0], shreg[WIDTH-1]};
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               cnt   <= cnt + 5'd1;
               if (cnt == 5'(WIDTH - 1)) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               bcd_q  <= acc;
               for (int i = 0; i < 6; i++) begin
                  hex_q[i] <= hex_next[i];
               end
               ovf_q  <= ovf_pend;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.hex0      = hex_q[0];
   assign bus.hex1      = hex_q[1];
   assign bus.hex2      = hex_q[2];
   assign bus.hex3      = hex_q[3];
   assign bus.hex4      = hex_q[4];
   assign bus.hex5      = hex_q[5];
   assign bus.bcd       = bcd_q;
   assign bus.busy      = busy_q;
   assign bus.ovf       = ovf_q;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_sc_io_display.sv
// tb_sc_io_display
//   Bench for sc_io_display. A reference model computes the expected display
//   from decimal arithmetic (saturate, divide by powers of ten) and the
//   segment table; directed cases and random values are compared against it.
module tb_sc_io_display;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sc_io_display_if bus ();

   sc_io_display #(.WIDTH(20)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [6:0] hex_obs [6];
   assign hex_obs[0] = bus.hex0;
   assign hex_obs[1] = bus.hex1;
   assign hex_obs[2] = bus.hex2;
   assign hex_obs[3] = bus.hex3;
   assign hex_obs[4] = bus.hex4;
   assign hex_obs[5] = bus.hex5;

`ifdef SC_IO_DISPLAY_BLANK_EN
   localparam bit BLANK_BUILD = 1'b1;
`else
   localparam bit BLANK_BUILD = 1'b0;
`endif

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // ---------------- reference model ----------------
   logic [19:0] model_last;

   function automatic int sat_of(input logic [19:0] v);
      int s;
      s = int'(v);
      if (s > 999999) s = 999999;
      return s;
   endfunction

   function automatic logic [23:0] model_bcd(input logic [19:0] v);
      int s;
      int p;
      logic [23:0] r;
      s = sat_of(v);
      p = 1;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'((s / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] model_hex(input logic [19:0] v, input int idx);
      int s;
      int p;
      s = sat_of(v);
      p = 1;
      for (int i = 0; i < idx; i++) p = p * 10;
      if (BLANK_BUILD && idx > 0 && s < p) return 7'h7F;
      return seg_tab[(s / p) % 10];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_result(input logic [31:0] v);
      @(negedge clk);
      bus.result = v;
   endtask

   // Counts negedge samples with busy high; returns once busy falls again.
   task automatic wait_conv(output int busy_cycles, output bit timed_out);
      busy_cycles = 0;
      timed_out   = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.busy) begin
            busy_cycles++;
         end else if (busy_cycles > 0) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int busy_seen;
      reset = 1'b1;
      bus.result = 32'd0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.bcd !== 24'd0 || bus.busy !== 1'b0 || bus.ovf !== 1'b0 || bus.state_dbg !== 2'd0)
         $display("FAIL reset_regs: bcd=%h busy=%b ovf=%b state=%0d, need 0/0/0/0",
                  bus.bcd, bus.busy, bus.ovf, bus.state_dbg);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (hex_obs[i] !== model_hex(20'd0, i))
            $display("FAIL reset_hex%0d: got %h need %h", i, hex_obs[i], model_hex(20'd0, i));
         else n_pass++;
      end
      reset = 1'b0;
      model_last = 20'd0;
      busy_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.busy) busy_seen++;
      end
      n_checks++;
      if (busy_seen != 0 || bus.bcd !== 24'd0 || bus.hex0 !== 7'h40)
         $display("FAIL idle_zero: busy_cycles=%0d bcd=%h hex0=%h, need 0/000000/40",
                  busy_seen, bus.bcd, bus.hex0);
      else n_pass++;
   endtask

   task automatic test_directed();
      logic [31:0] vals    [4] = '{32'd123456, 32'hFFF00042, 32'd1000000, 32'd7};
      logic [23:0] exp_bcd [4] = '{24'h123456, 24'h000066, 24'h999999, 24'h000007};
      logic        exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      int bc;
      bit to;
      for (int k = 0; k < 4; k++) begin
         drive_result(vals[k]);
         wait_conv(bc, to);
         model_last = vals[k][19:0];
         n_checks++;
         if (to || bc != 21)
            $display("FAIL dir_busy[%0d]: busy_cycles=%0d timeout=%b, need 21/0", k, bc, to);
         else n_pass++;
         n_checks++;
         if (bus.bcd !== exp_bcd[k] || bus.ovf !== exp_ovf[k])
            $display("FAIL dir_bcd[%0d]: bcd=%h ovf=%b, need %h/%b",
                     k, bus.bcd, bus.ovf, exp_bcd[k], exp_ovf[k]);
         else n_pass++;
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (hex_obs[i] !== model_hex(vals[k][19:0], i))
               $display("FAIL dir_hex%0d[%0d]: got %h need %h",
                        i, k, hex_obs[i], model_hex(vals[k][19:0], i));
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      logic [19:0] v;
      logic [31:0] hi;
      int bc;
      bit to;
      for (int k = 0; k < 16; k++) begin
         if ($urandom_range(0, 3) == 0) v = 20'($urandom_range(999990, 1048575));
         else v = 20'($urandom_range(0, 999999));
         if (v == model_last) v = v ^ 20'd1;
         hi = $urandom;
         drive_result({hi[11:0], v});
         wait_conv(bc, to);
         model_last = v;
         n_checks++;
         if (to || bc != 21)
            $display("FAIL rnd_busy[%0d]: busy_cycles=%0d timeout=%b, need 21/0", k, bc, to);
         else n_pass++;
         n_checks++;
         if (bus.bcd !== model_bcd(v) || bus.ovf !== (v > 20'd999999))
            $display("FAIL rnd_bcd[%0d] v=%0d: bcd=%h ovf=%b, need %h/%b",
                     k, v, bus.bcd, bus.ovf, model_bcd(v), (v > 20'd999999));
         else n_pass++;
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (hex_obs[i] !== model_hex(v, i))
               $display("FAIL rnd_hex%0d[%0d] v=%0d: got %h need %h",
                        i, k, v, hex_obs[i], model_hex(v, i));
            else n_pass++;
         end
      end
   endtask

   task automatic test_upper_bits();
      int busy_seen;
      logic [23:0] exp;
      exp = model_bcd(model_last);
      busy_seen = 0;
      for (int k = 0; k < 4; k++) begin
         drive_result({12'($urandom), model_last});
         repeat (6) begin
            @(negedge clk);
            if (bus.busy) busy_seen++;
         end
      end
      n_checks++;
      if (busy_seen != 0 || bus.bcd !== exp)
         $display("FAIL upper_bits: busy_cycles=%0d bcd=%h, need 0/%h", busy_seen, bus.bcd, exp);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      // Capture edge E for 111111, change to 222222 just after E+5.
      @(negedge clk);
      bus.result = 32'd111111;
      @(posedge clk);                    // E
      repeat (5) @(posedge clk);         // E+5
      #1 bus.result = 32'd222222;
      repeat (15) @(posedge clk);        // E+20
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.bcd !== model_bcd(model_last))
         $display("FAIL b2b_hold: busy=%b bcd=%h, need 1/%h", bus.busy, bus.bcd, model_bcd(model_last));
      else n_pass++;
      @(posedge clk);                    // E+21
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.bcd !== 24'h111111 || bus.hex5 !== 7'h79)
         $display("FAIL b2b_first: busy=%b bcd=%h hex5=%h, need 0/111111/79",
                  bus.busy, bus.bcd, bus.hex5);
      else n_pass++;
      @(posedge clk);                    // E+22
      #1;
      n_checks++;
      if (bus.busy !== 1'b1)
         $display("FAIL b2b_retrigger: busy=%b need 1", bus.busy);
      else n_pass++;
      repeat (20) @(posedge clk);        // E+42
      @(negedge clk);
      n_checks++;
      if (bus.bcd !== 24'h111111)
         $display("FAIL b2b_no_intermediate: bcd=%h need 111111", bus.bcd);
      else n_pass++;
      @(posedge clk);                    // E+43
      @(negedge clk);
      model_last = 20'd222222;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.bcd !== 24'h222222 || bus.hex0 !== 7'h24)
         $display("FAIL b2b_second: busy=%b bcd=%h hex0=%h, need 0/222222/24",
                  bus.busy, bus.bcd, bus.hex0);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int bc;
      bit to;
      @(negedge clk);
      bus.result = 32'd999999;
      @(posedge clk);                    // E
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.bcd !== 24'd0 || bus.ovf !== 1'b0 || bus.state_dbg !== 2'd0)
         $display("FAIL mid_reset_regs: busy=%b bcd=%h ovf=%b state=%0d, need 0/0/0/0",
                  bus.busy, bus.bcd, bus.ovf, bus.state_dbg);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (hex_obs[i] !== model_hex(20'd0, i))
            $display("FAIL mid_reset_hex%0d: got %h need %h", i, hex_obs[i], model_hex(20'd0, i));
         else n_pass++;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_last = 20'd0;
      wait_conv(bc, to);
      model_last = 20'd999999;
      n_checks++;
      if (to || bc != 21 || bus.bcd !== 24'h999999 || bus.ovf !== 1'b0)
         $display("FAIL mid_reset_rerun: busy_cycles=%0d timeout=%b bcd=%h ovf=%b, need 21/0/999999/0",
                  bc, to, bus.bcd, bus.ovf);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (hex_obs[i] !== 7'h10)
            $display("FAIL mid_reset_hex%0d_after: got %h need 10", i, hex_obs[i]);
         else n_pass++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1;
      bus.result = 32'd0;
      model_last = 20'd0;
      test_reset();
      test_directed();
      test_random();
      test_upper_bits();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
